// File: rtl/filter_rule_table.sv
// filter_rule_table: AXI-Lite rule table with shadow/active registers and deferred atomic commit
module filter_rule_table #(
  parameter int NUM_RULES = 4,
  parameter int ADDR_W = 10
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    s_awvalid,
  output logic                    s_awready,
  input  logic [ADDR_W-1:0]       s_awaddr,
  input  logic                    s_wvalid,
  output logic                    s_wready,
  input  logic [31:0]             s_wdata,
  input  logic [3:0]              s_wstrb,
  output logic                    s_bvalid,
  input  logic                    s_bready,
  output logic [1:0]              s_bresp,
  input  logic                    s_arvalid,
  output logic                    s_arready,
  input  logic [ADDR_W-1:0]       s_araddr,
  output logic                    s_rvalid,
  input  logic                    s_rready,
  output logic [31:0]             s_rdata,
  output logic [1:0]              s_rresp,
  input  logic                    pkt_busy,
  output logic [48*NUM_RULES-1:0] rule_mac,
  output logic [16*NUM_RULES-1:0] rule_ethertype,
  output logic [8*NUM_RULES-1:0]  rule_ip_proto,
  output logic [32*NUM_RULES-1:0] rule_ip_base,
  output logic [32*NUM_RULES-1:0] rule_ip_mask,
  output logic [16*NUM_RULES-1:0] rule_udp_port,
  output logic [NUM_RULES-1:0]    rule_en,
  output logic [7:0]              cfg_gen,
  output logic                    commit_done
);
  logic [47:0] sh_mac [NUM_RULES], a_mac [NUM_RULES];
  logic [15:0] sh_eth [NUM_RULES], a_eth [NUM_RULES];
  logic [7:0]  sh_proto [NUM_RULES], a_proto [NUM_RULES];
  logic [31:0] sh_base [NUM_RULES], a_base [NUM_RULES];
  logic [31:0] sh_mask [NUM_RULES], a_mask [NUM_RULES];
  logic [15:0] sh_udp [NUM_RULES], a_udp [NUM_RULES];
  logic        sh_en [NUM_RULES], a_en [NUM_RULES];
  logic [31:0] shw [NUM_RULES][8];
  logic [31:0] w_cur, w_val, r_val;
  logic        w_ok, r_ok, wr, rd, cp, commit, unused;
  assign wr = s_awvalid & s_wvalid & !s_bvalid;
  assign rd = s_arvalid & !s_rvalid;
  assign s_awready = wr;
  assign s_wready = wr;
  assign s_arready = !s_rvalid;
  assign commit = cp & !pkt_busy;
  assign unused = ^{s_awaddr[1:0], s_araddr[1:0]};
  always_comb begin
    w_cur = '0;
    w_val = '0;
    w_ok = s_awaddr[9] && s_awaddr[4:2] == 3'd0;
    r_ok = s_araddr[9] && s_araddr[4:2] <= 3'd2;
    r_val = !s_araddr[9] ? 32'hDEADBEEF :
            s_araddr[4:2] == 3'd0 ? 32'h0 :
            s_araddr[4:2] == 3'd1 ? {31'b0, cp} :
            s_araddr[4:2] == 3'd2 ? {24'b0, cfg_gen} : 32'hDEADBEEF;
    for (int r = 0; r < NUM_RULES; r++) begin
      shw[r][0] = sh_mac[r][31:0];
      shw[r][1] = {16'b0, sh_mac[r][47:32]};
      shw[r][2] = {16'b0, sh_eth[r]};
      shw[r][3] = {24'b0, sh_proto[r]};
      shw[r][4] = sh_base[r];
      shw[r][5] = sh_mask[r];
      shw[r][6] = {16'b0, sh_udp[r]};
      shw[r][7] = {31'b0, sh_en[r]};
      if (!s_awaddr[9] && s_awaddr[8:5] == 4'(r)) begin
        w_cur = shw[r][s_awaddr[4:2]];
        w_ok = 1'b1;
      end
      if (!s_araddr[9] && s_araddr[8:5] == 4'(r)) begin
        r_val = shw[r][s_araddr[4:2]];
        r_ok = 1'b1;
      end
    end
    for (int b = 0; b < 4; b++) w_val[8*b+:8] = s_wstrb[b] ? s_wdata[8*b+:8] : w_cur[8*b+:8];
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int r = 0; r < NUM_RULES; r++) begin
        sh_mac[r] <= 48'hCAFE_DEADBEEF;
        a_mac[r] <= 48'hCAFE_DEADBEEF;
        sh_eth[r] <= 16'h0800;
        a_eth[r] <= 16'h0800;
        sh_proto[r] <= 8'h11;
        a_proto[r] <= 8'h11;
        sh_base[r] <= 32'h0A000100;
        a_base[r] <= 32'h0A000100;
        sh_mask[r] <= 32'hFFFFFFFC;
        a_mask[r] <= 32'hFFFFFFFC;
        sh_udp[r] <= 16'd25565;
        a_udp[r] <= 16'd25565;
        sh_en[r] <= r == 0;
        a_en[r] <= r == 0;
      end
      cp <= 1'b0;
      cfg_gen <= '0;
      commit_done <= 1'b0;
      s_bvalid <= 1'b0;
      s_bresp <= '0;
      s_rvalid <= 1'b0;
      s_rdata <= '0;
      s_rresp <= '0;
    end else begin
      s_bvalid <= wr | (s_bvalid & !s_bready);
      if (wr) s_bresp <= w_ok ? 2'b00 : 2'b10;
      s_rvalid <= rd | (s_rvalid & !s_rready);
      if (rd) begin
        s_rdata <= r_val;
        s_rresp <= r_ok ? 2'b00 : 2'b10;
      end
      commit_done <= commit;
      if (commit) begin
        a_mac <= sh_mac;
        a_eth <= sh_eth;
        a_proto <= sh_proto;
        a_base <= sh_base;
        a_mask <= sh_mask;
        a_udp <= sh_udp;
        a_en <= sh_en;
        cfg_gen <= cfg_gen + 8'd1;
      end
      cp <= (cp & !commit) | (wr & w_ok & s_awaddr[9] & s_wstrb[0] & s_wdata[0]);
      for (int r = 0; r < NUM_RULES; r++)
        if (wr && !s_awaddr[9] && s_awaddr[8:5] == 4'(r))
          case (s_awaddr[4:2])
            3'd0: sh_mac[r][31:0] <= w_val;
            3'd1: sh_mac[r][47:32] <= w_val[15:0];
            3'd2: sh_eth[r] <= w_val[15:0];
            3'd3: sh_proto[r] <= w_val[7:0];
            3'd4: sh_base[r] <= w_val;
            3'd5: sh_mask[r] <= w_val;
            3'd6: sh_udp[r] <= w_val[15:0];
            default: sh_en[r] <= w_val[0];
          endcase
    end
  end
  for (genvar i = 0; i < NUM_RULES; i++) begin : g_out
    assign rule_mac[48*i+:48] = a_mac[i];
    assign rule_ethertype[16*i+:16] = a_eth[i];
    assign rule_ip_proto[8*i+:8] = a_proto[i];
    assign rule_ip_base[32*i+:32] = a_base[i];
    assign rule_ip_mask[32*i+:32] = a_mask[i];
    assign rule_udp_port[16*i+:16] = a_udp[i];
    assign rule_en[i] = a_en[i];
  end
endmodule

// File: tb/tb_filter_rule_table.sv
// tb_filter_rule_table: scoreboard bench for filter_rule_table bus, commit and reset behaviour
module tb_filter_rule_table;
  logic clk = 0, rst_n = 0;
  logic s_awvalid = 0, s_wvalid = 0, s_bready = 1, s_arvalid = 0, s_rready = 1, pkt_busy = 0;
  logic [9:0] s_awaddr = '0, s_araddr = '0;
  logic [31:0] s_wdata = '0;
  logic [3:0] s_wstrb = '0;
  logic s_awready, s_wready, s_bvalid, s_arready, s_rvalid, commit_done;
  logic [1:0] s_bresp, s_rresp;
  logic [31:0] s_rdata;
  logic [191:0] rule_mac;
  logic [63:0] rule_ethertype, rule_udp_port;
  logic [31:0] rule_ip_proto;
  logic [127:0] rule_ip_base, rule_ip_mask;
  logic [3:0] rule_en;
  logic [7:0] cfg_gen;
  int n_pass = 0, n_tot = 0, n_cd = 0;
  logic [1:0] bq [$];
  logic [33:0] rq [$];
  filter_rule_table #(.NUM_RULES(4), .ADDR_W(10)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr),
    .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp),
    .pkt_busy(pkt_busy),
    .rule_mac(rule_mac), .rule_ethertype(rule_ethertype), .rule_ip_proto(rule_ip_proto),
    .rule_ip_base(rule_ip_base), .rule_ip_mask(rule_ip_mask), .rule_udp_port(rule_udp_port),
    .rule_en(rule_en), .cfg_gen(cfg_gen), .commit_done(commit_done)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask
  always @(negedge clk) if (rst_n) begin
    if (commit_done) n_cd++;
    if (s_bvalid && s_bready) begin
      if (bq.size() == 0) begin
        n_tot++;
        $display("FAIL bresp_unexpected: got response %h with nothing outstanding", s_bresp);
      end else chk("bresp", 64'(s_bresp), 64'(bq.pop_front()));
    end
    if (s_rvalid && s_rready) begin
      if (rq.size() == 0) begin
        n_tot++;
        $display("FAIL rdata_unexpected: got %h with nothing outstanding", s_rdata);
      end else chk("rresp_rdata", 64'({s_rresp, s_rdata}), 64'(rq.pop_front()));
    end
  end
  task automatic drain();
    int k;
    for (k = 0; k < 50 && (bq.size() != 0 || rq.size() != 0); k++) @(posedge clk);
    if (bq.size() != 0 || rq.size() != 0) begin
      n_tot++;
      $display("FAIL drain_timeout: got %0d/%0d outstanding want 0", bq.size(), rq.size());
      bq.delete();
      rq.delete();
    end
  endtask
  task automatic wait_ready(input string nm, input bit aw);
    int k;
    for (k = 0; k < 50; k++) begin
      @(negedge clk);
      if (aw ? s_awready : s_arready) break;
    end
    if (k == 50) begin
      n_tot++;
      $display("FAIL %s_timeout: got ready=0 want 1", nm);
    end
  endtask
  task automatic wr(input logic [9:0] a, input logic [31:0] d, input logic [3:0] s, input logic [1:0] r);
    bq.push_back(r);
    @(posedge clk) #1;
    s_awaddr = a; s_wdata = d; s_wstrb = s; s_awvalid = 1; s_wvalid = 1;
    wait_ready("awready", 1);
    @(posedge clk) #1;
    s_awvalid = 0; s_wvalid = 0;
    drain();
  endtask
  task automatic rd(input logic [9:0] a, input logic [31:0] d, input logic [1:0] r);
    rq.push_back({r, d});
    @(posedge clk) #1;
    s_araddr = a; s_arvalid = 1;
    wait_ready("arready", 0);
    @(posedge clk) #1;
    s_arvalid = 0;
    drain();
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end
  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    @(negedge clk);
    chk("rst_rule_en", 64'(rule_en), 64'h1);
    chk("rst_cfg_gen", 64'(cfg_gen), 64'h0);
    chk("rst_commit_done", 64'(commit_done), 64'h0);
    chk("rst_bvalid", 64'(s_bvalid), 64'h0);
    chk("rst_rvalid", 64'(s_rvalid), 64'h0);
    chk("rst_arready", 64'(s_arready), 64'h1);
    chk("rst_mac0", 64'(rule_mac[47:0]), 64'hCAFE_DEADBEEF);
    chk("rst_udp1", 64'(rule_udp_port[31:16]), 64'd25565);
    chk("rst_mask3", 64'(rule_ip_mask[127:96]), 64'hFFFFFFFC);
    rd(10'h000, 32'hDEADBEEF, 2'b00);
    rd(10'h004, 32'h0000CAFE, 2'b00);
    rd(10'h01C, 32'h1, 2'b00);
    rd(10'h03C, 32'h0, 2'b00);
    wr(10'h030, 32'hC0A80000, 4'b0011, 2'b00);
    rd(10'h030, 32'h0A000000, 2'b00);
    rd(10'h033, 32'h0A000000, 2'b00);
    chk("pre_commit_base1", 64'(rule_ip_base[63:32]), 64'h0A000100);
    @(posedge clk) #1 pkt_busy = 1;
    wr(10'h200, 32'h1, 4'b0001, 2'b00);
    rd(10'h204, 32'h1, 2'b00);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("busy_base1", 64'(rule_ip_base[63:32]), 64'h0A000100);
      chk("busy_commit_done", 64'(commit_done), 64'h0);
    end
    chk("busy_cfg_gen", 64'(cfg_gen), 64'h0);
    @(posedge clk) #1 pkt_busy = 0;
    @(negedge clk);
    chk("predrop_base1", 64'(rule_ip_base[63:32]), 64'h0A000100);
    @(negedge clk);
    chk("commit_done_pulse", 64'(commit_done), 64'h1);
    chk("commit_cfg_gen", 64'(cfg_gen), 64'h1);
    chk("commit_base1", 64'(rule_ip_base[63:32]), 64'h0A000000);
    @(negedge clk);
    chk("commit_done_low", 64'(commit_done), 64'h0);
    rd(10'h204, 32'h0, 2'b00);
    rd(10'h208, 32'h1, 2'b00);
    wr(10'h0A0, 32'hFFFFFFFF, 4'hF, 2'b10);
    wr(10'h204, 32'h1, 4'hF, 2'b10);
    wr(10'h208, 32'hFF, 4'hF, 2'b10);
    wr(10'h21C, 32'h1, 4'hF, 2'b10);
    rd(10'h20C, 32'hDEADBEEF, 2'b10);
    rd(10'h0A0, 32'hDEADBEEF, 2'b10);
    rd(10'h204, 32'h0, 2'b00);
    rd(10'h208, 32'h1, 2'b00);
    chk("slverr_cfg_gen", 64'(cfg_gen), 64'h1);
    wr(10'h040, 32'h11223344, 4'hF, 2'b00);
    wr(10'h044, 32'h12345678, 4'hF, 2'b00);
    wr(10'h048, 32'hAABBCCDD, 4'b0100, 2'b00);
    wr(10'h04C, 32'h00000006, 4'b0001, 2'b00);
    wr(10'h05C, 32'h1, 4'b0001, 2'b00);
    rd(10'h044, 32'h00005678, 2'b00);
    rd(10'h048, 32'h00000800, 2'b00);
    rd(10'h04C, 32'h6, 2'b00);
    chk("precommit_en", 64'(rule_en), 64'h1);
    wr(10'h200, 32'h1, 4'b0001, 2'b00);
    repeat (2) @(negedge clk);
    chk("commit2_en", 64'(rule_en), 64'h5);
    chk("commit2_mac2", 64'(rule_mac[143:96]), 64'h5678_11223344);
    chk("commit2_proto2", 64'(rule_ip_proto[23:16]), 64'h06);
    chk("commit2_eth2", 64'(rule_ethertype[47:32]), 64'h0800);
    chk("commit2_cfg_gen", 64'(cfg_gen), 64'h2);
    @(posedge clk) #1;
    s_bready = 0; s_awaddr = 10'h058; s_wdata = 32'h1234; s_wstrb = 4'hF; s_awvalid = 1; s_wvalid = 1;
    bq.push_back(2'b00);
    @(posedge clk) #1;
    s_awaddr = 10'h078; s_wdata = 32'h4321;
    bq.push_back(2'b00);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_bvalid", 64'(s_bvalid), 64'h1);
      chk("bp_awready", 64'(s_awready), 64'h0);
      chk("bp_wready", 64'(s_wready), 64'h0);
    end
    @(posedge clk) #1 s_bready = 1;
    wait_ready("bp_awready", 1);
    @(posedge clk) #1;
    s_awvalid = 0; s_wvalid = 0;
    drain();
    @(posedge clk) #1;
    s_rready = 0; s_araddr = 10'h058; s_arvalid = 1;
    rq.push_back({2'b00, 32'h1234});
    @(posedge clk) #1;
    s_araddr = 10'h078;
    rq.push_back({2'b00, 32'h4321});
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_rvalid", 64'(s_rvalid), 64'h1);
      chk("bp_arready", 64'(s_arready), 64'h0);
      chk("bp_rdata", 64'(s_rdata), 64'h1234);
    end
    @(posedge clk) #1 s_rready = 1;
    wait_ready("bp_arready", 0);
    @(posedge clk) #1 s_arvalid = 0;
    drain();
    for (int i = 0; i < 253; i++) wr(10'h200, 32'h1, 4'b0001, 2'b00);
    repeat (2) @(negedge clk);
    chk("gen_255", 64'(cfg_gen), 64'hFF);
    chk("commit3_udp3", 64'(rule_udp_port[63:48]), 64'h4321);
    wr(10'h200, 32'h1, 4'b0001, 2'b00);
    repeat (2) @(negedge clk);
    chk("gen_wrap", 64'(cfg_gen), 64'h0);
    chk("commit_pulses", 64'(n_cd), 64'd256);
    @(posedge clk) #1 pkt_busy = 1;
    wr(10'h200, 32'h1, 4'b0001, 2'b00);
    rd(10'h204, 32'h1, 2'b00);
    @(posedge clk) #1 rst_n = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1; pkt_busy = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_rst_commit_done", 64'(commit_done), 64'h0);
    end
    chk("post_rst_cfg_gen", 64'(cfg_gen), 64'h0);
    chk("post_rst_en", 64'(rule_en), 64'h1);
    chk("post_rst_mac2", 64'(rule_mac[143:96]), 64'hCAFE_DEADBEEF);
    chk("post_rst_udp3", 64'(rule_udp_port[63:48]), 64'd25565);
    chk("post_rst_base1", 64'(rule_ip_base[63:32]), 64'h0A000100);
    chk("post_rst_bvalid", 64'(s_bvalid), 64'h0);
    rd(10'h204, 32'h0, 2'b00);
    rd(10'h058, 32'd25565, 2'b00);
    rd(10'h05C, 32'h0, 2'b00);
    chk("final_commit_pulses", 64'(n_cd), 64'd256);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule

// File: doc/filter_rule_table.md
Name: filter_rule_table

Overview:
Multi-rule successor to the single-rule filter configuration block. Holds NUM_RULES independent filter rule sets behind a full AXI-Lite-style slave: separate write-address, write-data, write-response, read-address and read-data handshakes, with byte strobes. Writes land in shadow registers. Shadow contents are copied atomically to the active registers driving the match logic only on a software commit, and the copy is deferred while a packet is in flight. This lets rules change without tearing.

Parameters:
NUM_RULES, 4, number of rule sets (1..16)
ADDR_W, 10, byte address width (fixed map below assumes 10)

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
s_awvalid  in  1  write address valid
s_awready  out  1  write address ready
s_awaddr  in  ADDR_W  write byte address
s_wvalid  in  1  write data valid
s_wready  out  1  write data ready
s_wdata  in  32  write data
s_wstrb  in  4  byte write strobes
s_bvalid  out  1  write response valid
s_bready  in  1  write response ready
s_bresp  out  2  00 OKAY, 10 SLVERR
s_arvalid  in  1  read address valid
s_arready  out  1  read address ready
s_araddr  in  ADDR_W  read byte address
s_rvalid  out  1  read data valid
s_rready  in  1  read data ready
s_rdata  out  32  read data
s_rresp  out  2  00 OKAY, 10 SLVERR
pkt_busy  in  1  match logic is mid-packet; commit must wait
rule_mac  out  48*NUM_RULES  active MAC, rule i at [48i+:48]
rule_ethertype  out  16*NUM_RULES  active ethertype
rule_ip_proto  out  8*NUM_RULES  active IP protocol
rule_ip_base  out  32*NUM_RULES  active IP base
rule_ip_mask  out  32*NUM_RULES  active IP mask
rule_udp_port  out  16*NUM_RULES  active UDP destination port
rule_en  out  NUM_RULES  active rule enable
cfg_gen  out  8  commit generation counter
commit_done  out  1  one-cycle pulse when a commit is applied

Behaviour:
- Address map:
  - addr[9]=0 selects rule space: rule = addr[8:5], word = addr[4:2]. Words: 0 mac[31:0], 1 mac[47:32], 2 ethertype, 3 ip_proto, 4 ip_base, 5 ip_mask, 6 udp_port, 7 ctrl (bit0 enable).
  - addr[9]=1 selects global space: word 0 CTRL (W; bit0 = commit request, reads 0), word 1 STATUS (RO; bit0 commit_pending), word 2 GEN (RO; cfg_gen in [7:0]).
  - addr[1:0] are ignored.
- Unmapped addresses: rule index >= NUM_RULES, or global word > 2. Writes to these, or to STATUS/GEN, return SLVERR and have no effect.
- Write handshake:
  - s_awready = s_wready = s_awvalid & s_wvalid & !s_bvalid, so address and data are accepted together in one cycle.
  - s_bvalid rises the next cycle and holds until s_bready is sampled high.
  - No second write is accepted while s_bvalid=1.
- Byte strobes: s_wstrb applies per byte. Bytes beyond a field's width are discarded. Narrow fields read back zero-extended.
- Read handshake:
  - s_arready = !s_rvalid.
  - On accept, s_rdata/s_rresp are registered and s_rvalid rises next cycle, holding until s_rready.
  - Rule-space reads return shadow values.
  - Unmapped reads return 32'hDEADBEEF with SLVERR.
- Reads and writes are independent and may complete in the same cycle.
- Commit:
  - A write of CTRL with bit0=1 and wstrb[0]=1 sets commit_pending. A repeat write while pending has no additional effect.
  - On any edge where commit_pending=1 and pkt_busy=0, all shadow registers are copied to active in that same edge.
  - The same edge clears commit_pending, increments cfg_gen (wraps 255 to 0), and pulses commit_done high for exactly one cycle.
  - A shadow write accepted on the commit edge is not part of the copy; the copy uses pre-edge shadow values. The write updates shadow only.
  - If the CTRL write is accepted while pkt_busy=0, the copy occurs on the following edge at the earliest.
  - While pkt_busy=1, active outputs never change.
- Reset (synchronous, rst_n=0 sampled at the edge):
  - Shadow and active for every rule: mac 48'hCAFE_DEADBEEF, ethertype 16'h0800, ip_proto 8'h11, ip_base 32'h0A000100, ip_mask 32'hFFFFFFFC, udp_port 16'd25565.
  - Enable: rule 0 enable=1; all other rules enable=0.
  - Handshake and status outputs: s_bvalid=0, s_rvalid=0, s_rdata=0, s_bresp=0, s_rresp=0, cfg_gen=0, commit_done=0, commit_pending=0.
  - Ready outputs follow their equations after reset.
  - Any in-flight transaction is dropped. Pending commits are cancelled.

Test Plan:
- Reset, then read 0x000, 0x004, 0x01C -> 32'hDEADBEEF, 32'h0000CAFE, 32'h1, all OKAY. rule_en=4'b0001, cfg_gen=0.
- Write 0x030 (rule1 ip_base) = 32'hC0A80000 with wstrb=4'b0011 -> shadow reads 32'h0A000000. rule_ip_base[63:32] stays 32'h0A000100 until commit.
- Set pkt_busy=1, write CTRL 0x200=1, hold busy 10 cycles -> STATUS reads 1 and outputs unchanged. Drop busy -> active updates on the next edge, commit_done pulses once, cfg_gen=1.
- Write 0x0A0 (rule 5, NUM_RULES=4) and 0x204 -> both SLVERR, no state change. Read 0x20C -> 32'hDEADBEEF, SLVERR.
- Hold s_bready=0 for 5 cycles after a write -> s_bvalid held high, s_awready=0 throughout. Same for s_rready/s_rvalid/s_arready.
- Issue 256 commits -> cfg_gen wraps to 0. Assert rst_n=0 with commit pending -> pending cleared, all outputs at reset values.
